// File: rtl/shift_ctrl_if.sv
// ============================================================
// shift_ctrl_if : command handshake bundle for shift_ctrl. Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

interface shift_ctrl_if #(
  parameter int CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [3:0]       cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_count, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_count, cmd_data,
    output cmd_ready
  );
endinterface

`default_nettype wire

// File: rtl/shift_ctrl.sv
// ============================================================
// shift_ctrl : load/rotate/ASR command sequencer for a 4-bit shift datapath.
// Macro SHIFT_CTRL_QUEUE_EN adds a one-entry pending command. Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module shift_ctrl #(
  parameter int CNT_W = 4
) (
  input  wire logic       clock,
  input  wire logic       reset,
  shift_ctrl_if.slave     cmd,
  input  wire logic [3:0] shift_q,
  output logic            shift_loadn,
  output logic            shift_rotr,
  output logic            shift_asr,
  output logic [3:0]      shift_data,
  output logic            busy,
  output logic            done,
  output logic [3:0]      result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ROTR = 2'b01;
  localparam logic [1:0] OP_ASR  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       data_q, data_d;

  logic             accept;
  logic             start_en;
  logic [1:0]       start_op;
  logic [CNT_W-1:0] start_cnt;
  logic [3:0]       start_data;

  assign accept = cmd.cmd_valid & cmd.cmd_ready;

`ifdef SHIFT_CTRL_QUEUE_EN
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_op_q, pend_op_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic [3:0]       pend_data_q, pend_data_d;

  assign cmd.cmd_ready = ~pend_valid_q;

  // A stored command wins in IDLE/DONE; ready is low then, so no new accept competes.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_op_d    = pend_op_q;
    pend_cnt_d   = pend_cnt_q;
    pend_data_d  = pend_data_q;
    start_en     = 1'b0;
    start_op     = cmd.cmd_op;
    start_cnt    = cmd.cmd_count;
    start_data   = cmd.cmd_data;
    if ((state_q == ST_IDLE || state_q == ST_DONE) && pend_valid_q) begin
      start_en     = 1'b1;
      start_op     = pend_op_q;
      start_cnt    = pend_cnt_q;
      start_data   = pend_data_q;
      pend_valid_d = 1'b0;
    end else if (state_q == ST_IDLE && accept) begin
      start_en = 1'b1;
    end
    if (accept && state_q != ST_IDLE) begin
      pend_valid_d = 1'b1;
      pend_op_d    = cmd.cmd_op;
      pend_cnt_d   = cmd.cmd_count;
      pend_data_d  = cmd.cmd_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_op_q    <= 2'b00;
      pend_cnt_q   <= '0;
      pend_data_q  <= 4'd0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_op_q    <= pend_op_d;
      pend_cnt_q   <= pend_cnt_d;
      pend_data_q  <= pend_data_d;
    end
  end
`else
  assign cmd.cmd_ready = (state_q == ST_IDLE);

  always_comb begin
    start_en   = (state_q == ST_IDLE) && accept;
    start_op   = cmd.cmd_op;
    start_cnt  = cmd.cmd_count;
    start_data = cmd.cmd_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE:  state_d = ST_IDLE;
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (start_en) begin
      op_d   = start_op;
      cnt_d  = start_cnt;
      data_d = start_data;
      if (start_op == OP_LOAD) begin
        state_d = ST_LOAD;
      end else if (start_cnt != '0) begin
        state_d = ST_SHIFT;
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      cnt_q   <= '0;
      data_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Outside SHIFT the datapath is always in parallel load, recirculating Q unless loading.
  assign shift_loadn = (state_q == ST_SHIFT);
  assign shift_rotr  = (state_q == ST_SHIFT) && (op_q == OP_ROTR || op_q == OP_ASR);
  assign shift_asr   = (state_q == ST_SHIFT) && (op_q == OP_ASR);
  assign shift_data  = (state_q == ST_LOAD) ? data_q : shift_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign result      = (state_q == ST_DONE) ? shift_q : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_shift_ctrl.sv
// ============================================================
// tb_shift_ctrl : randomized self-checking bench for shift_ctrl. Rev 1.0
// ============================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shift_ctrl;
  localparam int CNT_W = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] shift_q, shift_data, result;
  logic       shift_loadn, shift_rotr, shift_asr, busy, done;
  logic [3:0] dp_q = 4'd0;
  int         n_tests = 0;
  int         n_fail  = 0;

  shift_ctrl_if #(.CNT_W(CNT_W)) cmd_bus ();

  shift_ctrl #(.CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd        (cmd_bus.slave),
    .shift_q    (shift_q),
    .shift_loadn(shift_loadn),
    .shift_rotr (shift_rotr),
    .shift_asr  (shift_asr),
    .shift_data (shift_data),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  always #5 clock = ~clock;

  // Datapath being controlled
  assign shift_q = dp_q;
  always @(posedge clock) begin
    if (!shift_loadn)    dp_q <= shift_data;
    else if (shift_asr)  dp_q <= {dp_q[3], dp_q[3:1]};
    else if (shift_rotr) dp_q <= {dp_q[0], dp_q[3:1]};
    else                 dp_q <= {dp_q[2:0], dp_q[3]};
  end

  // Expected register value after a command, from plain arithmetic
  function automatic logic [3:0] ref_result(input logic [1:0] op, input int n,
                                            input logic [3:0] q, input logic [3:0] d);
    logic [7:0] two;
    int k, v;
    two = {q, q};
    k = n % 4;
    case (op)
      2'b00: return d;
      2'b01: begin two = two >> k; return two[3:0]; end
      2'b10: begin two = two << k; return two[7:4]; end
      default: begin
        v = q[3] ? int'(q) - 16 : int'(q);
        v = v >>> n;
        return v[3:0];
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input int n, input logic [3:0] d,
                       output logic [3:0] q0, output logic rdy);
    @(negedge clock);
    q0  = dp_q;
    rdy = cmd_bus.cmd_ready;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_count = CNT_W'(n);
    cmd_bus.cmd_data  = d;
    @(posedge clock);
    #1 cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [1:0] op, output int cyc, output logic [3:0] res,
                           output int nshift, output int nbad);
    cyc = -1; res = 4'd0; nshift = 0; nbad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (shift_loadn) begin
        nshift++;
        if (shift_rotr !== (op != 2'b10) || shift_asr !== (op == 2'b11)) nbad++;
      end else if (shift_asr !== 1'b0) nbad++;
      if (busy !== 1'b1) nbad++;
      if (!done && result !== 4'd0) nbad++;
      if (done) begin cyc = k; res = result; return; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_op = 2'b00;
    cmd_bus.cmd_count = '0;   cmd_bus.cmd_data = 4'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_tests++;
    if ({cmd_bus.cmd_ready, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_hs: ready/busy/done=%b expected 100", {cmd_bus.cmd_ready, busy, done});
    end
    n_tests++;
    if ({shift_loadn, shift_rotr, shift_asr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctl: loadn/rotr/asr=%b expected 000", {shift_loadn, shift_rotr, shift_asr});
    end
    n_tests++;
    if (result !== 4'd0 || shift_data !== shift_q) begin
      n_fail++; $display("FAIL reset_data: result=%h data=%h expected 0 and %h", result, shift_data, shift_q);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_load;
    logic [3:0] q0, res; logic rdy; int cyc, nsh, nbad, bad_hold;
    issue(2'b00, 0, 4'b1011, q0, rdy);
    wait_done(2'b00, cyc, res, nsh, nbad);
    n_tests++;
    if (cyc != 2 || res !== 4'b1011 || nbad != 0) begin
      n_fail++; $display("FAIL load: cyc=%0d res=%b bad=%0d expected 2 1011 0", cyc, res, nbad);
    end
    bad_hold = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (dp_q !== 4'b1011 || shift_asr !== 1'b0 || busy !== 1'b0) bad_hold++;
    end
    n_tests++;
    if (bad_hold != 0) begin
      n_fail++; $display("FAIL idle_hold: bad cycles=%0d expected 0 (q=%b)", bad_hold, dp_q);
    end
  endtask

  task automatic test_rotate;
    logic [3:0] q0, res; logic rdy; int cyc, nsh, nbad;
    issue(2'b00, 0, 4'b1011, q0, rdy); wait_done(2'b00, cyc, res, nsh, nbad);
    issue(2'b01, 1, 4'd0, q0, rdy);    wait_done(2'b01, cyc, res, nsh, nbad);
    n_tests++;
    if (cyc != 2 || res !== 4'b1101 || nsh != 1 || nbad != 0) begin
      n_fail++; $display("FAIL rotr1: cyc=%0d res=%b shifts=%0d bad=%0d expected 2 1101 1 0", cyc, res, nsh, nbad);
    end
    issue(2'b00, 0, 4'b0001, q0, rdy); wait_done(2'b00, cyc, res, nsh, nbad);
    issue(2'b10, 5, 4'd0, q0, rdy);    wait_done(2'b10, cyc, res, nsh, nbad);
    n_tests++;
    if (cyc != 6 || res !== 4'b0010 || nsh != 5 || nbad != 0) begin
      n_fail++; $display("FAIL rotl5: cyc=%0d res=%b shifts=%0d bad=%0d expected 6 0010 5 0", cyc, res, nsh, nbad);
    end
  endtask

  task automatic test_asr;
    logic [3:0] q0, res; logic rdy; int cyc, nsh, nbad;
    issue(2'b00, 0, 4'b1000, q0, rdy); wait_done(2'b00, cyc, res, nsh, nbad);
    issue(2'b11, 2, 4'd0, q0, rdy);    wait_done(2'b11, cyc, res, nsh, nbad);
    n_tests++;
    if (cyc != 3 || res !== 4'b1110 || nbad != 0) begin
      n_fail++; $display("FAIL asr2: cyc=%0d res=%b bad=%0d expected 3 1110 0", cyc, res, nbad);
    end
    issue(2'b00, 0, 4'b0110, q0, rdy); wait_done(2'b00, cyc, res, nsh, nbad);
    issue(2'b11, 3, 4'd0, q0, rdy);    wait_done(2'b11, cyc, res, nsh, nbad);
    n_tests++;
    if (cyc != 4 || res !== 4'b0000 || nbad != 0) begin
      n_fail++; $display("FAIL asr3: cyc=%0d res=%b bad=%0d expected 4 0000 0", cyc, res, nbad);
    end
  endtask

  task automatic test_zero_count;
    logic [3:0] q0, res; logic rdy; int cyc, nsh, nbad;
    issue(2'b00, 0, 4'b0101, q0, rdy); wait_done(2'b00, cyc, res, nsh, nbad);
    issue(2'b01, 0, 4'd0, q0, rdy);    wait_done(2'b01, cyc, res, nsh, nbad);
    n_tests++;
    if (cyc != 1 || res !== 4'b0101 || nsh != 0) begin
      n_fail++; $display("FAIL zero_count: cyc=%0d res=%b shifts=%0d expected 1 0101 0", cyc, res, nsh);
    end
  endtask

`ifndef SHIFT_CTRL_QUEUE_EN
  task automatic test_hold_valid;
    logic [3:0] q0, expv; int ready_hi;
    @(negedge clock);
    q0 = dp_q;
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_op = 2'b01;
    cmd_bus.cmd_count = CNT_W'(3); cmd_bus.cmd_data = 4'd0;
    @(posedge clock);
    #1 cmd_bus.cmd_op = 2'b00; cmd_bus.cmd_data = 4'b0110; cmd_bus.cmd_count = '0;
    expv = ref_result(2'b01, 3, q0, 4'd0);
    ready_hi = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (cmd_bus.cmd_ready !== 1'b0) ready_hi++;
      if (k == 4) begin
        n_tests++;
        if (done !== 1'b1 || result !== expv) begin
          n_fail++; $display("FAIL hold_done: done=%b res=%b expected 1 %b", done, result, expv);
        end
      end
    end
    n_tests++;
    if (ready_hi != 0) begin
      n_fail++; $display("FAIL hold_ready: ready high in %0d busy cycles, expected 0", ready_hi);
    end
    @(negedge clock);
    n_tests++;
    if (cmd_bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_idle: ready=%b busy=%b expected 1 0", cmd_bus.cmd_ready, busy);
    end
    @(posedge clock);
    #1 cmd_bus.cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_tests++;
    if (done !== 1'b1 || result !== 4'b0110) begin
      n_fail++; $display("FAIL hold_second: done=%b res=%b expected 1 0110", done, result);
    end
  endtask
`else
  task automatic test_queue;
    int nshift;
    @(negedge clock);
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_op = 2'b00;
    cmd_bus.cmd_count = '0;   cmd_bus.cmd_data = 4'b0001;
    @(posedge clock);
    #1 cmd_bus.cmd_op = 2'b10; cmd_bus.cmd_count = CNT_W'(2); cmd_bus.cmd_data = 4'd0;
    @(negedge clock);
    n_tests++;
    if (cmd_bus.cmd_ready !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL q_accept: ready=%b busy=%b expected 1 1", cmd_bus.cmd_ready, busy);
    end
    @(posedge clock);
    #1 cmd_bus.cmd_valid = 1'b0;
    @(negedge clock);
    n_tests++;
    if (done !== 1'b1 || result !== 4'b0001) begin
      n_fail++; $display("FAIL q_first: done=%b res=%b expected 1 0001", done, result);
    end
    nshift = 0;
    for (int k = 3; k <= 4; k++) begin
      @(negedge clock);
      if (shift_loadn === 1'b1 && done === 1'b0) nshift++;
    end
    n_tests++;
    if (nshift != 2) begin
      n_fail++; $display("FAIL q_shift: shift cycles=%0d expected 2", nshift);
    end
    @(negedge clock);
    n_tests++;
    if (done !== 1'b1 || result !== 4'b0100) begin
      n_fail++; $display("FAIL q_second: done=%b res=%b expected 1 0100", done, result);
    end
  endtask
`endif

  task automatic test_reset_abort;
    logic [3:0] q0; logic rdy; int done_seen;
    issue(2'b01, 4, 4'd0, q0, rdy);
    @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({busy, cmd_bus.cmd_ready, done} !== 3'b010) begin
      n_fail++; $display("FAIL abort_hs: busy/ready/done=%b expected 010", {busy, cmd_bus.cmd_ready, done});
    end
    n_tests++;
    if (shift_loadn !== 1'b0 || shift_asr !== 1'b0) begin
      n_fail++; $display("FAIL abort_ctl: loadn=%b asr=%b expected 0 0", shift_loadn, shift_asr);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    n_tests++;
    if (done_seen != 0) begin
      n_fail++; $display("FAIL abort_quiet: done/busy seen in %0d cycles, expected 0", done_seen);
    end
  endtask

  task automatic test_random;
    logic [1:0] op; logic [3:0] d, q0, res, expv; logic rdy;
    int n, cyc, ecyc, nsh, nbad;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      n  = int'($urandom_range(0, 15));
      d  = 4'($urandom_range(0, 15));
      issue(op, n, d, q0, rdy);
      wait_done(op, cyc, res, nsh, nbad);
      expv = ref_result(op, n, q0, d);
      ecyc = (op == 2'b00) ? 2 : ((n == 0) ? 1 : n + 1);
      n_tests++;
      if (rdy !== 1'b1) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: ready=%b expected 1", i, rdy);
      end
      n_tests++;
      if (cyc != ecyc) begin
        n_fail++; $display("FAIL rnd_latency[%0d]: op=%0d n=%0d cyc=%0d expected %0d", i, op, n, cyc, ecyc);
      end
      n_tests++;
      if (res !== expv) begin
        n_fail++; $display("FAIL rnd_result[%0d]: op=%0d n=%0d q0=%b res=%b expected %b", i, op, n, q0, res, expv);
      end
      n_tests++;
      if (nsh != ((op == 2'b00) ? 0 : n) || nbad != 0) begin
        n_fail++; $display("FAIL rnd_ctl[%0d]: shifts=%0d bad=%0d expected %0d 0", i, nsh, nbad, (op == 2'b00) ? 0 : n);
      end
      @(negedge clock);
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || cmd_bus.cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd_idle[%0d]: busy=%b done=%b ready=%b expected 0 0 1", i, busy, done, cmd_bus.cmd_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_rotate();
    test_asr();
    test_zero_count();
`ifndef SHIFT_CTRL_QUEUE_EN
    test_hold_valid();
`else
    test_queue();
`endif
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
